// File: rtl/wgt_addr_pkg.sv
// Shared types and width helpers for the weight-RAM address generator.
package wgt_addr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_ADDR  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int BEAT_W = 15;

    function automatic int size_w(input int systolic_size);
        return $clog2(systolic_size) + 1;
    endfunction

    // Beat count must hold 9 * (2^CH_W - 1) without truncation.
    function automatic int beat_w(input int ch_w);
        return (ch_w + 4 > BEAT_W) ? ch_w + 4 : BEAT_W;
    endfunction

endpackage

// File: rtl/wgt_tile_calc.sv
// Per-layer tile geometry, captured once on layer_start so the multiply and
// divide stay off the address path.
module wgt_tile_calc
    import wgt_addr_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int CH_W          = 11
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              load,
    input  logic [1:0]                        kernel_size,
    input  logic [CH_W-1:0]                   num_channel,
    input  logic [CH_W-1:0]                   num_filter,
    output logic [beat_w(CH_W)-1:0]           beats,
    output logic [CH_W:0]                     ntiles,
    output logic [size_w(SYSTOLIC_SIZE)-1:0]  last_size,
    output logic                              empty
);

    localparam int SHIFT = $clog2(SYSTOLIC_SIZE);
    localparam int SZ_W  = size_w(SYSTOLIC_SIZE);
    localparam int BW    = beat_w(CH_W);
    localparam int NT_W  = CH_W + 1;

    logic [3:0]      kk;
    logic [NT_W-1:0] f_round;
    logic [BW-1:0]   beats_d,     beats_q;
    logic [NT_W-1:0] ntiles_d,    ntiles_q;
    logic [SZ_W-1:0] last_size_d, last_size_q;
    logic            empty_d,     empty_q;

    always_comb begin
        kk      = {2'b00, kernel_size} * {2'b00, kernel_size};
        beats_d = BW'(kk) * BW'(num_channel);
        f_round = {1'b0, num_filter} + NT_W'(SYSTOLIC_SIZE - 1);
        empty_d = (beats_d == '0) || (num_filter == '0);
        // An empty layer still owes exactly one (beat-less) tile.
        ntiles_d = empty_d ? NT_W'(1) : (f_round >> SHIFT);
        last_size_d = (num_filter[SHIFT-1:0] == '0) ? SZ_W'(SYSTOLIC_SIZE)
                                                    : SZ_W'(num_filter[SHIFT-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_q     <= '0;
            ntiles_q    <= '0;
            last_size_q <= SZ_W'(SYSTOLIC_SIZE);
            empty_q     <= 1'b0;
        end else if (load) begin
            beats_q     <= beats_d;
            ntiles_q    <= ntiles_d;
            last_size_q <= last_size_d;
            empty_q     <= empty_d;
        end
    end

    assign beats     = beats_q;
    assign ntiles    = ntiles_q;
    assign last_size = last_size_q;
    assign empty     = empty_q;

endmodule

// File: rtl/wgt_addr_gen.sv
// Weight-RAM address generator: one filter tile of kernel^2*channel beats per
// tile_req, with a contiguous address pointer running across the whole layer.
module wgt_addr_gen
    import wgt_addr_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int ADDR_W        = 24,
    parameter int CH_W          = 11
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              layer_start,
    input  logic                              tile_req,
    input  logic [1:0]                        kernel_size,
    input  logic [CH_W-1:0]                   num_channel,
    input  logic [CH_W-1:0]                   num_filter,
    input  logic [ADDR_W-1:0]                 layer_base_addr,
    input  logic                              rd_ready,
    output logic [ADDR_W-1:0]                 wgt_addr,
    output logic                              rd_en,
    output logic [$clog2(SYSTOLIC_SIZE):0]    rd_size,
    output logic                              tile_done,
    output logic                              layer_done,
    output logic                              busy,
    output logic [1:0]                        dbg_state
);

    localparam int SZ_W = size_w(SYSTOLIC_SIZE);
    localparam int BW   = beat_w(CH_W);
    localparam int NT_W = CH_W + 1;

    logic [BW-1:0]   beats;
    logic [NT_W-1:0] ntiles;
    logic [SZ_W-1:0] last_size;
    logic            empty;

    wgt_tile_calc #(
        .SYSTOLIC_SIZE (SYSTOLIC_SIZE),
        .CH_W          (CH_W)
    ) u_tile_calc (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (layer_start),
        .kernel_size (kernel_size),
        .num_channel (num_channel),
        .num_filter  (num_filter),
        .beats       (beats),
        .ntiles      (ntiles),
        .last_size   (last_size),
        .empty       (empty)
    );

    state_t          state_d,      state_q;
    logic [ADDR_W-1:0] ptr_d,      ptr_q;
    logic [NT_W-1:0] tile_idx_d,   tile_idx_q;
    logic [BW-1:0]   beat_cnt_d,   beat_cnt_q;
    logic            rd_en_d,      rd_en_q;
    logic [SZ_W-1:0] rd_size_d,    rd_size_q;
    logic            tile_done_d,  tile_done_q;
    logic            layer_done_d, layer_done_q;
    logic            busy_d,       busy_q;
    logic [BW-1:0]   beat_nxt;
    logic            last_tile;

    // Handshake: a beat transfers on a cycle with rd_en && rd_ready; while
    // rd_en is high and rd_ready low, wgt_addr, rd_size and rd_en are held.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        tile_idx_d   = tile_idx_q;
        beat_cnt_d   = beat_cnt_q;
        rd_en_d      = rd_en_q;
        rd_size_d    = rd_size_q;
        tile_done_d  = 1'b0;
        layer_done_d = 1'b0;
        beat_nxt     = beat_cnt_q + BW'(1);
        last_tile    = (tile_idx_q == ntiles - NT_W'(1));

        if (layer_start) begin
            state_d    = ST_IDLE;
            rd_en_d    = 1'b0;
            ptr_d      = layer_base_addr;
            tile_idx_d = '0;
            beat_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tile_req && (tile_idx_q < ntiles)) begin
                        if (empty) begin
                            state_d      = ST_DONE;
                            tile_done_d  = 1'b1;
                            layer_done_d = last_tile;
                            tile_idx_d   = tile_idx_q + NT_W'(1);
                        end else begin
                            state_d = ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    rd_size_d  = last_tile ? last_size : SZ_W'(SYSTOLIC_SIZE);
                    beat_cnt_d = '0;
                    rd_en_d    = 1'b1;
                    state_d    = ST_ADDR;
                end
                ST_ADDR: begin
                    if (rd_ready) begin
                        ptr_d      = ptr_q + ADDR_W'(rd_size_q);
                        beat_cnt_d = beat_nxt;
                        if (beat_nxt == beats) begin
                            rd_en_d      = 1'b0;
                            state_d      = ST_DONE;
                            tile_done_d  = 1'b1;
                            layer_done_d = last_tile;
                            tile_idx_d   = tile_idx_q + NT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            tile_idx_q   <= '0;
            beat_cnt_q   <= '0;
            rd_en_q      <= 1'b0;
            rd_size_q    <= SZ_W'(SYSTOLIC_SIZE);
            tile_done_q  <= 1'b0;
            layer_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            tile_idx_q   <= tile_idx_d;
            beat_cnt_q   <= beat_cnt_d;
            rd_en_q      <= rd_en_d;
            rd_size_q    <= rd_size_d;
            tile_done_q  <= tile_done_d;
            layer_done_q <= layer_done_d;
            busy_q       <= busy_d;
        end
    end

    assign wgt_addr   = ptr_q;
    assign rd_en      = rd_en_q;
    assign rd_size    = rd_size_q;
    assign tile_done  = tile_done_q;
    assign layer_done = layer_done_q;
    assign busy       = busy_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_wgt_addr_gen.sv
// Bench for wgt_addr_gen: layer table, random back-pressure, abort, empty layer
// and asynchronous reset, with a queue of expected {address, size} beats.
module tb_wgt_addr_gen;

    localparam int S   = 16;
    localparam int AW  = 24;
    localparam int CW  = 11;
    localparam int SZW = 5;
    localparam int W   = AW + SZW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          layer_start = 1'b0;
    logic          tile_req = 1'b0;
    logic [1:0]    kernel_size = 2'd1;
    logic [CW-1:0] num_channel = '0;
    logic [CW-1:0] num_filter = '0;
    logic [AW-1:0] layer_base_addr = '0;
    logic          rd_ready = 1'b1;
    logic [AW-1:0] wgt_addr;
    logic          rd_en;
    logic [SZW-1:0] rd_size;
    logic          tile_done;
    logic          layer_done;
    logic          busy;
    logic [1:0]    dbg_state;

    wgt_addr_gen #(
        .SYSTOLIC_SIZE (S),
        .ADDR_W        (AW),
        .CH_W          (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .layer_start     (layer_start),
        .tile_req        (tile_req),
        .kernel_size     (kernel_size),
        .num_channel     (num_channel),
        .num_filter      (num_filter),
        .layer_base_addr (layer_base_addr),
        .rd_ready        (rd_ready),
        .wgt_addr        (wgt_addr),
        .rd_en           (rd_en),
        .rd_size         (rd_size),
        .tile_done       (tile_done),
        .layer_done      (layer_done),
        .busy            (busy),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / reset / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- shared state ----------------
    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];
    int accept_cnt = 0;
    bit rand_ready = 1'b0;
    bit rd_en_seen = 1'b0;
    logic [AW-1:0] m_ptr = '0;
    int m_tile = 0;

    typedef struct {
        logic [1:0]    k;
        int            c;
        int            f;
        logic [AW-1:0] base;
        int            ntiles;
        int            last;
    } cfg_t;

    cfg_t cfg_tab[4];
    cfg_t cfg_empty;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // ---------------- rd_ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic           prev_stall = 1'b0;
    logic [AW-1:0]  prev_addr = '0;
    logic [SZW-1:0] prev_size = '0;

    initial begin
        logic [W-1:0] exp;
        forever begin
            @(negedge clk);
            if (rd_en) rd_en_seen = 1'b1;
            if (prev_stall && rst_n)
                check("stall_hold", {2'b00, rd_en, wgt_addr, rd_size}, {2'b00, 1'b1, prev_addr, prev_size});
            if (rst_n && rd_en && rd_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got addr 0x%0h size %0d, required no beat", wgt_addr, rd_size);
                end else begin
                    exp = exp_q.pop_front();
                    check("beat", {3'b000, wgt_addr, rd_size}, {3'b000, exp});
                end
                accept_cnt++;
            end
            prev_stall = rst_n && rd_en && !rd_ready;
            prev_addr  = wgt_addr;
            prev_size  = rd_size;
        end
    end

    // ---------------- driver tasks (called at posedge + 1) ----------------
    task automatic start_layer(input cfg_t cfg);
        kernel_size     = cfg.k;
        num_channel     = CW'(cfg.c);
        num_filter      = CW'(cfg.f);
        layer_base_addr = cfg.base;
        layer_start     = 1'b1;
        @(posedge clk);
        #1;
        layer_start = 1'b0;
        m_ptr  = cfg.base;
        m_tile = 0;
        exp_q.delete();
    endtask

    task automatic push_tile(input cfg_t cfg);
        int beats;
        int size;
        beats = int'(cfg.k) * int'(cfg.k) * cfg.c;
        size  = (m_tile == cfg.ntiles - 1) ? cfg.last : S;
        for (int b = 0; b < beats; b++) begin
            exp_q.push_back({m_ptr, SZW'(size)});
            m_ptr = m_ptr + AW'(size);
        end
    endtask

    task automatic run_tile(input cfg_t cfg);
        int beats;
        int acc0;
        int first;
        int bound;
        bit done;
        bit last;
        beats = int'(cfg.k) * int'(cfg.k) * cfg.c;
        last  = (m_tile == cfg.ntiles - 1);
        push_tile(cfg);
        acc0  = accept_cnt;
        first = 0;
        done  = 1'b0;
        bound = 4 * beats + 20;
        tile_req = 1'b1;
        @(posedge clk);
        #1;
        tile_req = 1'b0;
        @(negedge clk);
        check("busy_setup", {31'd0, busy}, 32'd1);
        for (int cyc = 2; cyc <= bound && !done; cyc++) begin
            @(negedge clk);
            if (rd_en && first == 0) first = cyc;
            if (tile_done) begin
                done = 1'b1;
                check("layer_done", {31'd0, layer_done}, {31'd0, last});
            end
        end
        check("tile_done_seen", {31'd0, done}, 32'd1);
        check("first_beat_latency", first, 2);
        check("beats_accepted", accept_cnt - acc0, beats);
        check("queue_empty", exp_q.size(), 0);
        m_tile++;
        @(posedge clk);
        #1;
    endtask

    task automatic ignored_req(input string name);
        bit saw;
        saw = 1'b0;
        tile_req = 1'b1;
        @(posedge clk);
        #1;
        tile_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy || tile_done || layer_done || rd_en) saw = 1'b1;
        end
        check(name, {31'd0, saw}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wgt_addr"}, {8'd0, wgt_addr}, 32'd0);
        check({tag, "_rd_en"}, {31'd0, rd_en}, 32'd0);
        check({tag, "_rd_size"}, {27'd0, rd_size}, S);
        check({tag, "_tile_done"}, {31'd0, tile_done}, 32'd0);
        check({tag, "_layer_done"}, {31'd0, layer_done}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit done;
        bit saw;
        int first;

        cfg_tab[0] = '{2'd3, 4, 40, 24'h000100, 3, 8};
        cfg_tab[1] = '{2'd1, 2, 32, 24'h000000, 2, 16};
        cfg_tab[2] = '{2'd3, 5, 17, 24'hFFFF00, 2, 1};
        cfg_tab[3] = '{2'd1, 1, 16, 24'h123456, 1, 16};
        cfg_empty  = '{2'd3, 0, 40, 24'h000200, 1, 16};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        ignored_req("req_before_layer");

        // Table of layers, back-to-back tiles, then one surplus request.
        for (int i = 0; i < 4; i++) begin
            start_layer(cfg_tab[i]);
            for (int t = 0; t < cfg_tab[i].ntiles; t++) run_tile(cfg_tab[i]);
            ignored_req("req_after_last_tile");
        end

        // Same first layer under random back-pressure.
        rand_ready = 1'b1;
        start_layer(cfg_tab[0]);
        for (int t = 0; t < cfg_tab[0].ntiles; t++) run_tile(cfg_tab[0]);
        rand_ready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // Abort at beat 10 with a new base address.
        start_layer(cfg_tab[0]);
        push_tile(cfg_tab[0]);
        tile_req = 1'b1;
        @(posedge clk);
        #1;
        tile_req = 1'b0;
        done = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (rd_en && wgt_addr == 24'h000100 + 24'd160) done = 1'b1;
        end
        check("abort_reached_beat10", {31'd0, done}, 32'd1);
        layer_base_addr = 24'h008000;
        layer_start = 1'b1;
        @(posedge clk);
        #1;
        layer_start = 1'b0;
        @(negedge clk);
        check("abort_rd_en", {31'd0, rd_en}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_new_base", {8'd0, wgt_addr}, 32'h008000);
        exp_q.delete();
        saw = tile_done;
        repeat (3) begin
            @(negedge clk);
            if (tile_done) saw = 1'b1;
        end
        check("abort_no_tile_done", {31'd0, saw}, 32'd0);
        @(posedge clk);
        #1;
        m_ptr  = 24'h008000;
        m_tile = 0;
        run_tile(cfg_tab[0]);

        // Empty layer: a single beat-less tile.
        start_layer(cfg_empty);
        rd_en_seen = 1'b0;
        tile_req = 1'b1;
        @(posedge clk);
        #1;
        tile_req = 1'b0;
        done  = 1'b0;
        first = 0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            if (tile_done && !done) begin
                done  = 1'b1;
                first = cyc;
                check("empty_layer_done", {31'd0, layer_done}, 32'd1);
            end
        end
        check("empty_tile_done_seen", {31'd0, done}, 32'd1);
        check("empty_latency_le2", {31'd0, (first >= 1 && first <= 2)}, 32'd1);
        check("empty_no_rd_en", {31'd0, rd_en_seen}, 32'd0);
        @(posedge clk);
        #1;
        ignored_req("empty_second_req");

        // Asynchronous reset in the middle of a tile.
        start_layer(cfg_tab[0]);
        push_tile(cfg_tab[0]);
        tile_req = 1'b1;
        @(posedge clk);
        #1;
        tile_req = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_reset_in_addr", {31'd0, rd_en}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ignored_req("idle_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
